// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl_pkg
//  Description : Shared types and helpers for the fetch sequencing controller.
//                Holds the sequencer state encoding and the boot-counter
//                width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_ctrl_pkg;

    // Sequencer states: held after reset, normal fetch, waiting on imem.
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        IMISS = 2'd2
    } fetch_state_t;

    // The boot counter runs 0 .. cycles-1, so it needs clog2(cycles) bits,
    // with a floor of one bit so a single-cycle boot still has a register.
    function automatic int boot_cnt_w(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage : fetch_ctrl_pkg
`default_nettype wire

// File: rtl/fetch_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_seq_ctrl_if
//  Description : Bundle between the EX/hazard/imem side of the pipeline and
//                the fetch sequencing controller.
//                slave  : controller view (EX/hazard/imem in, PC/pipe ctl out)
//                master : datapath view (drives EX/hazard/imem, reads ctl)
//  Ports       : none (signal bundle only); D_WIDTH sets address width.
//  Revision    : 1.0  initial release
// ============================================================================
interface fetch_seq_ctrl_if #(
    parameter int D_WIDTH = 32
) ();

    // EX-stage redirect information
    logic               branch_e;
    logic               cond_e;
    logic               jump_e;
    logic               jalr_e;
    logic [D_WIDTH-1:0] pc_target_e;
    logic [D_WIDTH-1:0] result_e;
    // Hazard unit and instruction memory status
    logic               load_use_haz;
    logic               imem_ready;
    // PC block and pipeline register control
    logic               pc_src;
    logic [D_WIDTH-1:0] target;
    logic               pc_en;
    logic               stall_d;
    logic               flush_d;
    logic               flush_e;

    modport slave (
        input  branch_e, cond_e, jump_e, jalr_e, pc_target_e, result_e,
        input  load_use_haz, imem_ready,
        output pc_src, target, pc_en, stall_d, flush_d, flush_e
    );

    modport master (
        output branch_e, cond_e, jump_e, jalr_e, pc_target_e, result_e,
        output load_use_haz, imem_ready,
        input  pc_src, target, pc_en, stall_d, flush_d, flush_e
    );

endinterface : fetch_seq_ctrl_if
`default_nettype wire

// File: rtl/fetch_perf_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_perf_ctr
//  Description : Saturating event counter. Increments once per cycle while
//                i_en is high and sticks at all-ones.
//  Ports       : clk, rst_n (async active-low), i_en, o_cnt[WIDTH-1:0]
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_perf_ctr #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_en,
    output logic      [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule : fetch_perf_ctr
`default_nettype wire

// File: rtl/fetch_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_seq_ctrl
//  Description : Fetch sequencing controller. Each cycle decides whether the
//                PC advances, holds or redirects, and drives IF/ID and ID/EX
//                stall/flush. Resolves EX redirects (branch/JAL/JALR),
//                load-use stalls and imem wait states, and buffers one
//                redirect that arrives while a fetch miss is outstanding.
//  Ports       : clk, rst_n (async active-low)
//                ctrl  : fetch_seq_ctrl_if.slave (EX/hazard/imem in,
//                        pc_src/target/pc_en/stall_d/flush_d/flush_e out)
//                o_redir_cnt/o_stall_cnt/o_miss_cnt : perf counters
//                        (only with FETCH_PERF_EN)
//  Options     : FETCH_PERF_EN - adds the three saturating perf counters.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_seq_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int D_WIDTH     = 32,
    parameter int BOOT_CYCLES = 2
`ifdef FETCH_PERF_EN
    ,
    parameter int CNT_WIDTH   = 16
`endif
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    fetch_seq_ctrl_if.slave      ctrl
`ifdef FETCH_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0] o_redir_cnt,
    output logic [CNT_WIDTH-1:0] o_stall_cnt,
    output logic [CNT_WIDTH-1:0] o_miss_cnt
`endif
);

    localparam int                C_BOOT_CNT_W = boot_cnt_w(BOOT_CYCLES);
    localparam [C_BOOT_CNT_W-1:0] C_BOOT_LAST  = C_BOOT_CNT_W'(BOOT_CYCLES - 1);

    fetch_state_t            r_state;
    fetch_state_t            w_next_state;
    logic [C_BOOT_CNT_W-1:0] r_boot_cnt;
    logic                    r_pend_valid;
    logic [D_WIDTH-1:0]      r_pend_target;

    logic                    w_redir;
    logic [D_WIDTH-1:0]      w_redir_tgt;
    logic                    w_pend_set;
    logic                    w_pend_clr;
    logic                    w_unused;

    // JALR targets are forced half-word aligned; bit 0 of rs1+imm is dropped.
    assign w_redir     = (ctrl.branch_e & ctrl.cond_e) | ctrl.jump_e | ctrl.jalr_e;
    assign w_redir_tgt = ctrl.jalr_e ? {ctrl.result_e[D_WIDTH-1:1], 1'b0}
                                     : ctrl.pc_target_e;
    assign w_unused    = ctrl.result_e[0];

    // ------------------------------------------------------------------------
    // State, boot counter and pending-redirect registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_boot_cnt <= '0;
        end else if ((r_state == BOOT) && (r_boot_cnt != C_BOOT_LAST)) begin
            r_boot_cnt <= r_boot_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_valid  <= 1'b0;
            r_pend_target <= '0;
        end else if (w_pend_set) begin
            r_pend_valid  <= 1'b1;
            r_pend_target <= w_redir_tgt;
        end else if (w_pend_clr) begin
            r_pend_valid  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_pend_set   = 1'b0;
        w_pend_clr   = 1'b0;
        ctrl.pc_src  = 1'b0;
        ctrl.target  = '0;
        ctrl.pc_en   = 1'b0;
        ctrl.stall_d = 1'b0;
        ctrl.flush_d = 1'b0;
        ctrl.flush_e = 1'b0;

        case (r_state)
            BOOT: begin
                // PC held and pipe kept empty; EX/hazard inputs are don't-care.
                ctrl.flush_d = 1'b1;
                ctrl.flush_e = 1'b1;
                if (r_boot_cnt == C_BOOT_LAST) begin
                    w_next_state = RUN;
                end
            end

            RUN: begin
                if (w_redir) begin
                    ctrl.pc_src  = 1'b1;
                    ctrl.target  = w_redir_tgt;
                    ctrl.pc_en   = 1'b1;
                    ctrl.flush_d = 1'b1;
                    ctrl.flush_e = 1'b1;
                end else if (ctrl.load_use_haz) begin
                    ctrl.stall_d = 1'b1;
                    ctrl.flush_e = 1'b1;
                end else if (!ctrl.imem_ready) begin
                    ctrl.flush_d = 1'b1;
                    w_next_state = IMISS;
                end else begin
                    ctrl.pc_en   = 1'b1;
                end
            end

            IMISS: begin
                if (ctrl.imem_ready) begin
                    // Fetch returns: a live redirect beats a buffered one,
                    // either way the buffer is emptied on the way to RUN.
                    w_next_state = RUN;
                    w_pend_clr   = 1'b1;
                    if (w_redir) begin
                        ctrl.pc_src  = 1'b1;
                        ctrl.target  = w_redir_tgt;
                        ctrl.pc_en   = 1'b1;
                        ctrl.flush_d = 1'b1;
                        ctrl.flush_e = 1'b1;
                    end else if (r_pend_valid) begin
                        ctrl.pc_src  = 1'b1;
                        ctrl.target  = r_pend_target;
                        ctrl.pc_en   = 1'b1;
                        ctrl.flush_d = 1'b1;
                    end else begin
                        ctrl.pc_en   = 1'b1;
                    end
                end else if (w_redir) begin
                    // PC cannot move yet; kill the EX instruction and remember
                    // where to go once the outstanding fetch completes.
                    ctrl.target  = w_redir_tgt;
                    ctrl.flush_d = 1'b1;
                    ctrl.flush_e = 1'b1;
                    w_pend_set   = !r_pend_valid;
                end else if (ctrl.load_use_haz) begin
                    ctrl.stall_d = 1'b1;
                    ctrl.flush_e = 1'b1;
                end else begin
                    ctrl.flush_d = 1'b1;
                end
            end

            default: begin
                w_next_state = BOOT;
                ctrl.flush_d = 1'b1;
                ctrl.flush_e = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Optional performance counters
    // ------------------------------------------------------------------------
`ifdef FETCH_PERF_EN
    logic w_cnt_redir_en;
    logic w_cnt_stall_en;
    logic w_cnt_miss_en;

    assign w_cnt_redir_en = (r_state == RUN) && w_redir;
    assign w_cnt_stall_en = (r_state == RUN) && !w_redir && ctrl.load_use_haz;
    assign w_cnt_miss_en  = (r_state == IMISS) && !ctrl.imem_ready;

    fetch_perf_ctr #(.WIDTH(CNT_WIDTH)) u_redir_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_cnt_redir_en),
        .o_cnt (o_redir_cnt)
    );

    fetch_perf_ctr #(.WIDTH(CNT_WIDTH)) u_stall_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_cnt_stall_en),
        .o_cnt (o_stall_cnt)
    );

    fetch_perf_ctr #(.WIDTH(CNT_WIDTH)) u_miss_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_cnt_miss_en),
        .o_cnt (o_miss_cnt)
    );
`else
`endif

    // ------------------------------------------------------------------------
    // Protocol checks
    // ------------------------------------------------------------------------
    a_no_stall_and_flush : assert property (@(posedge clk) disable iff (!rst_n)
        !(ctrl.stall_d && ctrl.flush_d));

    a_stall_holds_pc : assert property (@(posedge clk) disable iff (!rst_n)
        ctrl.stall_d |-> !ctrl.pc_en);

    // Only one redirect can be buffered during a miss; a second is dropped.
    a_single_pending : assert property (@(posedge clk) disable iff (!rst_n)
        ((r_state == IMISS) && !ctrl.imem_ready && w_redir) |-> !r_pend_valid);

endmodule : fetch_seq_ctrl
`default_nettype wire

// File: tb/tb_fetch_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_seq_ctrl
//  Description : Self-checking bench for fetch_seq_ctrl. Directed scenarios
//                followed by randomized traffic, all compared each cycle
//                against a behavioural model of the sequencing rules.
//                Compile with FETCH_PERF_EN to include the perf counters.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_seq_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    fetch_seq_ctrl_if #(.D_WIDTH(32)) ifc ();

`ifdef FETCH_PERF_EN
    logic [15:0] redir_cnt;
    logic [15:0] stall_cnt;
    logic [15:0] miss_cnt;
`endif

    fetch_seq_ctrl #(
        .D_WIDTH     (32),
        .BOOT_CYCLES (2)
`ifdef FETCH_PERF_EN
        ,
        .CNT_WIDTH   (16)
`endif
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ctrl        (ifc)
`ifdef FETCH_PERF_EN
        ,
        .o_redir_cnt (redir_cnt),
        .o_stall_cnt (stall_cnt),
        .o_miss_cnt  (miss_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: cycles of boot hold left, whether a fetch is
    // outstanding, at most one buffered redirect, and event tallies.
    int          m_boot_left;
    bit          m_miss;
    logic [31:0] m_pend[$];
    int          m_rc;
    int          m_sc;
    int          m_mc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_boot_left = 2;
        m_miss      = 1'b0;
        m_pend.delete();
        m_rc        = 0;
        m_sc        = 0;
        m_mc        = 0;
    endtask

    task automatic check_perf(input string tag);
`ifdef FETCH_PERF_EN
        chk({tag, "_redir_cnt"}, 32'(redir_cnt), 32'(m_rc));
        chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(m_sc));
        chk({tag, "_miss_cnt"},  32'(miss_cnt),  32'(m_mc));
`else
        if (tag.len() == 0) $display("perf counters not built");
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pc_src"},  32'(ifc.pc_src),  32'd0);
        chk({tag, "_target"},  ifc.target,       32'd0);
        chk({tag, "_pc_en"},   32'(ifc.pc_en),   32'd0);
        chk({tag, "_stall_d"}, 32'(ifc.stall_d), 32'd0);
        chk({tag, "_flush_d"}, 32'(ifc.flush_d), 32'd1);
        chk({tag, "_flush_e"}, 32'(ifc.flush_e), 32'd1);
    endtask

    // Assert reset partway through a cycle, check outputs immediately,
    // then release just after a rising edge so the boot hold starts cleanly.
    task automatic apply_reset(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs(tag);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        check_perf(tag);
    endtask

    // One cycle: drive inputs, compare outputs with the rule model, advance.
    task automatic step(input logic br, input logic cnd, input logic jmp, input logic jr,
                        input logic [31:0] pt, input logic [31:0] rs,
                        input logic lu, input logic rdy);
        logic        redir;
        logic [31:0] tgt;
        logic        e_src, e_en, e_stall, e_fd, e_fe;
        logic [31:0] e_tgt;

        @(negedge clk);
        ifc.branch_e     = br;
        ifc.cond_e       = cnd;
        ifc.jump_e       = jmp;
        ifc.jalr_e       = jr;
        ifc.pc_target_e  = pt;
        ifc.result_e     = rs;
        ifc.load_use_haz = lu;
        ifc.imem_ready   = rdy;
        #1;

        redir = (br && cnd) || jmp || jr;
        tgt   = jr ? (rs & 32'hFFFF_FFFE) : pt;
        {e_src, e_en, e_stall, e_fd, e_fe} = 5'b0;
        e_tgt = 32'd0;

        if (m_boot_left > 0) begin
            e_fd = 1'b1;
            e_fe = 1'b1;
            m_boot_left--;
        end else if (!m_miss) begin
            if (redir) begin
                {e_src, e_en, e_fd, e_fe} = 4'b1111;
                e_tgt = tgt;
                m_rc++;
            end else if (lu) begin
                e_stall = 1'b1;
                e_fe    = 1'b1;
                m_sc++;
            end else if (!rdy) begin
                e_fd   = 1'b1;
                m_miss = 1'b1;
            end else begin
                e_en = 1'b1;
            end
        end else if (rdy) begin
            if (redir) begin
                {e_src, e_en, e_fd, e_fe} = 4'b1111;
                e_tgt = tgt;
            end else if (m_pend.size() != 0) begin
                {e_src, e_en, e_fd} = 3'b111;
                e_tgt = m_pend[0];
            end else begin
                e_en = 1'b1;
            end
            m_pend.delete();
            m_miss = 1'b0;
        end else begin
            m_mc++;
            if (redir) begin
                e_tgt = tgt;
                e_fd  = 1'b1;
                e_fe  = 1'b1;
                if (m_pend.size() == 0) m_pend.push_back(tgt);
            end else if (lu) begin
                e_stall = 1'b1;
                e_fe    = 1'b1;
            end else begin
                e_fd = 1'b1;
            end
        end

        chk("pc_src",  32'(ifc.pc_src),  32'(e_src));
        chk("target",  ifc.target,       e_tgt);
        chk("pc_en",   32'(ifc.pc_en),   32'(e_en));
        chk("stall_d", 32'(ifc.stall_d), 32'(e_stall));
        chk("flush_d", 32'(ifc.flush_d), 32'(e_fd));
        chk("flush_e", 32'(ifc.flush_e), 32'(e_fe));
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, rdy);
    endtask

    initial begin
        logic        br, cnd, jmp, jr, lu, rdy;
        logic [31:0] pt, rs;

        ifc.branch_e     = 1'b0;
        ifc.cond_e       = 1'b0;
        ifc.jump_e       = 1'b0;
        ifc.jalr_e       = 1'b0;
        ifc.pc_target_e  = '0;
        ifc.result_e     = '0;
        ifc.load_use_haz = 1'b0;
        ifc.imem_ready   = 1'b1;

        // Reset values and boot hold; EX inputs during boot must be ignored.
        apply_reset("rst0");
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'd0, 1'b1, 1'b1);
        chk("boot_pc_en_0", 32'(ifc.pc_en), 32'd0);
        idle(1'b1);
        chk("boot_pc_en_1", 32'(ifc.pc_en), 32'd0);
        idle(1'b1);
        chk("run_first_pc_en", 32'(ifc.pc_en), 32'd1);

        // Taken branch
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'd0, 1'b0, 1'b1);
        chk("br_target", ifc.target, 32'h100);
        // Not-taken branch advances normally
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h180, 32'd0, 1'b0, 1'b1);

        // JALR alignment, then JALR beating a load-use hazard
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h203, 1'b0, 1'b1);
        chk("jalr_target", ifc.target, 32'h202);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h311, 1'b1, 1'b1);
        chk("jalr_lu_stall", 32'(ifc.stall_d), 32'd0);

        // Single-cycle load-use stall
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        idle(1'b1);

        // Miss with a JAL arriving mid-miss, replayed when imem returns
        idle(1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h400, 32'd0, 1'b0, 1'b0);
        chk("miss_jal_flush_e", 32'(ifc.flush_e), 32'd1);
        idle(1'b0);
        idle(1'b1);
        chk("miss_replay_target", ifc.target, 32'h400);
        chk("miss_replay_src", 32'(ifc.pc_src), 32'd1);
        idle(1'b1);

        // Load-use during a miss, then redirect on the cycle imem returns
        idle(1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h440, 32'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h480, 32'd0, 1'b0, 1'b1);
        chk("miss_direct_target", ifc.target, 32'h480);
        idle(1'b1);
        chk("after_direct_src", 32'(ifc.pc_src), 32'd0);
        check_perf("dir");

        // Reset while a redirect is buffered: nothing stale afterwards
        idle(1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h500, 32'd0, 1'b0, 1'b0);
        apply_reset("rst1");
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("post_rst_src", 32'(ifc.pc_src), 32'd0);
        chk("post_rst_pc_en", 32'(ifc.pc_en), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                apply_reset("rst_rand");
            end
            rdy = ($urandom_range(0, 3) != 0);
            br  = ($urandom_range(0, 4) == 0);
            cnd = $urandom_range(0, 1) == 1;
            jmp = ($urandom_range(0, 11) == 0);
            jr  = ($urandom_range(0, 11) == 0);
            lu  = ($urandom_range(0, 5) == 0);
            pt  = $urandom & 32'hFFFF_FFFC;
            rs  = $urandom;
            // Keep to defined territory: never offer a second buffered
            // redirect, and keep load-use apart from miss completion and
            // mid-miss redirects.
            if (m_boot_left == 0 && m_miss && m_pend.size() != 0 && !rdy) begin
                br  = 1'b0;
                jmp = 1'b0;
                jr  = 1'b0;
            end
            if (m_boot_left == 0 && m_miss && (rdy || (br && cnd) || jmp || jr)) begin
                lu = 1'b0;
            end
            step(br, cnd, jmp, jr, pt, rs, lu, rdy);
            if ((i % 50) == 49) check_perf("rand");
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fetch_seq_ctrl
`default_nettype wire
